// File: rtl/ps2_keyboard_rx_if.sv
// Output bundle of the PS/2 keyboard receiver: the held-key level for the PIO
// plus the per-byte strobes.
interface ps2_keyboard_rx_if;
  logic [7:0] pio_keyboard_export;
  logic       code_valid;
  logic [7:0] code_byte;
  logic       frame_err;

  modport master (
    output pio_keyboard_export,
    output code_valid,
    output code_byte,
    output frame_err
  );

  modport slave (
    input pio_keyboard_export,
    input code_valid,
    input code_byte,
    input frame_err
  );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: synchronises and filters the PS/2 lines, frames
// 11-bit bytes and tracks make/break codes to present the currently held key.
module ps2_keyboard_rx #(
  parameter int FILT_LEN       = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  input  logic               ps2_clk,
  input  logic               ps2_dat,
  ps2_keyboard_rx_if.master  kbd,
  output logic [1:0]         dbg_state_o,
  output logic [1:0]         dbg_flags_o
);

  localparam int            TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic                clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic [FILT_LEN-1:0] filt_sr_q;
  logic                filt_q, filt_d, fall_q;

  state_t              state_q;
  logic [2:0]          bit_cnt_q;
  logic [7:0]          sr_q;
  logic                par_q;
  logic [TW-1:0]       tmo_q;
  logic                brk_q, ext_q;
  logic [7:0]          export_q, byte_q;
  logic                valid_q, err_q;

  // Filtered clock only moves when the whole sample window agrees.
  always_comb begin
    filt_d = filt_q;
    if (&filt_sr_q)       filt_d = 1'b1;
    else if (~|filt_sr_q) filt_d = 1'b0;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
      filt_sr_q <= '1;
      filt_q    <= 1'b1;
      fall_q    <= 1'b0;
    end else begin
      clk_s1_q  <= ps2_clk;
      clk_s2_q  <= clk_s1_q;
      dat_s1_q  <= ps2_dat;
      dat_s2_q  <= dat_s1_q;
      filt_sr_q <= {filt_sr_q[FILT_LEN-2:0], clk_s2_q};
      filt_q    <= filt_d;
      fall_q    <= filt_q & ~filt_d;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 3'd0;
      sr_q      <= 8'h00;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
      export_q  <= 8'h00;
      byte_q    <= 8'h00;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;

      if (fall_q || state_q == S_IDLE || tmo_q == TMO_MAX) tmo_q <= '0;
      else                                                 tmo_q <= tmo_q + TW'(1);

      if (fall_q) begin
        case (state_q)
          S_IDLE: begin
            if (!dat_s2_q) begin
              state_q   <= S_DATA;
              bit_cnt_q <= 3'd0;
            end
          end
          S_DATA: begin
            sr_q[bit_cnt_q] <= dat_s2_q;
            bit_cnt_q       <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
          end
          S_PARITY: begin
            par_q   <= dat_s2_q;
            state_q <= S_STOP;
          end
          S_STOP: begin
            state_q <= S_IDLE;
            if (dat_s2_q && (^{sr_q, par_q})) begin
              valid_q <= 1'b1;
              byte_q  <= sr_q;
              // Break only releases the export if it names the key shown.
              if (sr_q == 8'hF0) begin
                brk_q <= 1'b1;
              end else if (sr_q == 8'hE0) begin
                ext_q <= 1'b1;
              end else if (brk_q) begin
                if (sr_q == export_q) export_q <= 8'h00;
                brk_q <= 1'b0;
                ext_q <= 1'b0;
              end else begin
                export_q <= sr_q;
                ext_q    <= 1'b0;
              end
            end else begin
              err_q <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (state_q != S_IDLE && tmo_q == TMO_MAX) begin
        state_q <= S_IDLE;
        err_q   <= 1'b1;
        sr_q    <= 8'h00;
      end
    end
  end

  assign kbd.pio_keyboard_export = export_q;
  assign kbd.code_valid          = valid_q;
  assign kbd.code_byte           = byte_q;
  assign kbd.frame_err           = err_q;
  assign dbg_state_o             = state_q;
  assign dbg_flags_o             = {brk_q, ext_q};

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: table of frames with expected export, plus
// timeout, glitch and mid-frame reset sequences, checked through a scoreboard.
`timescale 1ns/1ps
module tb_ps2_keyboard_rx;

  localparam int HALF = 40;
  localparam int TMO  = 400;

  logic clk, rst, ps2_clk, ps2_dat;
  logic [1:0] dbg_state, dbg_flags;

  ps2_keyboard_rx_if kbd();

  ps2_keyboard_rx #(.FILT_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .ps2_clk     (ps2_clk),
    .ps2_dat     (ps2_dat),
    .kbd         (kbd),
    .dbg_state_o (dbg_state),
    .dbg_flags_o (dbg_flags)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: {is_err, code_byte, export}
  logic [16:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_err_cyc = 0;
  int last_fall_cyc = 0;

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       bad_stop;
    logic       exp_err;
    logic [7:0] exp_export;
  } vec_t;

  vec_t vecs[32];
  int   n_vec = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [7:0] d, input logic bp, input logic bs,
                         input logic e, input logic [7:0] x);
    vecs[n_vec].data       = d;
    vecs[n_vec].bad_par    = bp;
    vecs[n_vec].bad_stop   = bs;
    vecs[n_vec].exp_err    = e;
    vecs[n_vec].exp_export = x;
    n_vec++;
  endtask

  // Driver: bits LSB first, data set while ps2_clk is high.
  task automatic send_bits(input logic [10:0] f, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      ps2_dat = f[i];
      if (glitch && i == 3) begin
        repeat (15) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF - 20) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      if (glitch && i == 6) begin
        repeat (15) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF - 20) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bp, input logic bs, input bit glitch);
    logic p;
    p = (~^d) ^ bp;
    send_bits({~bs, p, d, 1'b0}, 11, glitch);
    ps2_dat = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget, input string name);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d expected events never seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_export"}, kbd.pio_keyboard_export, 8'h00);
    check({tag, "_valid"},  8'(kbd.code_valid),       8'h00);
    check({tag, "_byte"},   kbd.code_byte,            8'h00);
    check({tag, "_err"},    8'(kbd.frame_err),        8'h00);
    check({tag, "_state"},  8'(dbg_state),            8'h00);
  endtask

  // Monitor
  always @(negedge clk) begin
    logic [16:0] e;
    cyc++;
    if (!rst) begin
      if (kbd.code_valid && kbd.frame_err) begin
        n_cmp++;
        n_bad++;
        $display("FAIL exclusive: code_valid=1 frame_err=1 required not both");
      end else if (kbd.code_valid || kbd.frame_err) begin
        if (kbd.frame_err) last_err_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: valid=%0b err=%0b byte=%02h, none expected",
                   kbd.code_valid, kbd.frame_err, kbd.code_byte);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", 8'(kbd.frame_err), 8'(e[16]));
          if (kbd.code_valid) check("code_byte", kbd.code_byte, e[15:8]);
          check("export", kbd.pio_keyboard_export, e[7:0]);
        end
      end
    end
  end

  initial begin
    logic [7:0] last_good;
    int lat;
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (5) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    repeat (20) @(negedge clk);

    add_vec(8'h1C, 0, 0, 0, 8'h1C);
    add_vec(8'hF0, 0, 0, 0, 8'h1C);
    add_vec(8'h1C, 0, 0, 0, 8'h00);
    add_vec(8'h1C, 0, 0, 0, 8'h1C);
    add_vec(8'h1C, 0, 0, 0, 8'h1C);
    add_vec(8'h1B, 0, 0, 0, 8'h1B);
    add_vec(8'hF0, 0, 0, 0, 8'h1B);
    add_vec(8'h1C, 0, 0, 0, 8'h1B);
    add_vec(8'hF0, 0, 0, 0, 8'h1B);
    add_vec(8'h1B, 0, 0, 0, 8'h00);
    add_vec(8'h1C, 1, 0, 1, 8'h00);
    add_vec(8'h1C, 0, 0, 0, 8'h1C);
    add_vec(8'h1C, 1, 0, 1, 8'h1C);
    add_vec(8'h1C, 0, 1, 1, 8'h1C);
    add_vec(8'hE0, 0, 0, 0, 8'h1C);
    add_vec(8'h75, 0, 0, 0, 8'h75);
    add_vec(8'hE0, 0, 0, 0, 8'h75);
    add_vec(8'hF0, 0, 0, 0, 8'h75);
    add_vec(8'h75, 0, 0, 0, 8'h00);
    add_vec(8'h2A, 0, 0, 0, 8'h2A);
    add_vec(8'hF0, 0, 0, 0, 8'h2A);
    add_vec(8'h2A, 1, 0, 1, 8'h2A);
    add_vec(8'h2A, 0, 0, 0, 8'h00);
    add_vec(8'h11, 0, 0, 0, 8'h11);

    last_good = 8'h00;
    for (int i = 0; i < n_vec; i++) begin
      exp_q.push_back({vecs[i].exp_err, vecs[i].data, vecs[i].exp_export});
      send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop, 1'b0);
      wait_drain(300, "vec_drain");
      if (!vecs[i].exp_err) last_good = vecs[i].data;
      check("byte_held", kbd.code_byte, last_good);
      check("export_level", kbd.pio_keyboard_export, vecs[i].exp_export);
    end

    // Partial frame then silence: timeout error, export unchanged.
    exp_q.push_back({1'b1, 8'h00, 8'h11});
    send_bits({1'b1, 1'b1, 8'h55, 1'b0}, 5, 1'b0);
    ps2_dat = 1'b1;
    wait_drain(3 * TMO, "timeout_drain");
    lat = last_err_cyc - last_fall_cyc;
    n_cmp++;
    if (lat < TMO || lat > TMO + 40) begin
      n_bad++;
      $display("FAIL timeout_latency: got %0d cycles required %0d..%0d", lat, TMO, TMO + 40);
    end
    check("timeout_state", 8'(dbg_state), 8'h00);
    exp_q.push_back({1'b0, 8'h23, 8'h23});
    send_frame(8'h23, 0, 0, 1'b0);
    wait_drain(300, "after_timeout_drain");

    // Short glitches on ps2_clk in both phases.
    exp_q.push_back({1'b0, 8'h1C, 8'h1C});
    send_frame(8'h1C, 0, 0, 1'b1);
    wait_drain(300, "glitch_drain");

    // Reset in the middle of a frame.
    send_bits({1'b1, 1'b0, 8'h2B, 1'b0}, 6, 1'b0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    check("midreset_flags", 8'(dbg_flags), 8'h00);
    repeat (2 * TMO) @(negedge clk);
    exp_q.push_back({1'b0, 8'h1C, 8'h1C});
    send_frame(8'h1C, 0, 0, 1'b0);
    wait_drain(300, "after_reset_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
